// File: rtl/wb_commit_pkg.sv
// Shared types for the multi-lane writeback/commit stage: per-lane control word
// and the state classification helpers used at retirement.
package wb_commit_pkg;

    typedef enum logic [3:0] {
        s_idle, s_fetch, s_lui, s_aupic, s_jal, s_jalr,
        s_br, s_load, s_store, s_ri, s_rr, s_trap
    } state_e;

    typedef struct packed {
        state_e      state;
        logic [31:0] pc;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        imem_stall;
    } contw_t;

    function automatic logic is_retiring(state_e s);
        return s inside {s_lui, s_aupic, s_jal, s_jalr, s_br, s_load, s_store, s_ri, s_rr};
    endfunction

    function automatic logic is_reg_writer(state_e s);
        return is_retiring(s) && !(s inside {s_br, s_store});
    endfunction

endpackage

// File: rtl/wb_commit_if.sv
// MEM-facing group handshake plus regfile/RVFI retirement outputs of wb_commit.
interface wb_commit_if
    import wb_commit_pkg::*;
#(
    parameter int unsigned LANES   = 2,
    parameter int unsigned ORDER_W = 64
) ();

    logic   [LANES-1:0]              wb_valid;
    contw_t [LANES-1:0]              wb_pkt;
    logic                            wb_ready;
    logic                            flush;
    logic                            commit_stall;
    logic   [LANES-1:0]              regf_we;
    logic   [LANES-1:0][4:0]         rd_s_wb;
    logic   [LANES-1:0][31:0]        rd_v_wb;
    logic   [LANES-1:0]              commit;
    logic   [LANES-1:0][ORDER_W-1:0] rvfi_order;
    contw_t [LANES-1:0]              contw_rvfi;

    modport master (
        output wb_valid, wb_pkt, flush, commit_stall,
        input  wb_ready, regf_we, rd_s_wb, rd_v_wb, commit, rvfi_order, contw_rvfi
    );

    modport slave (
        input  wb_valid, wb_pkt, flush, commit_stall,
        output wb_ready, regf_we, rd_s_wb, rd_v_wb, commit, rvfi_order, contw_rvfi
    );

endinterface

// File: rtl/wb_commit_group_fifo.sv
// DEPTH-entry FIFO of whole retirement groups; flush empties it in one cycle.
module wb_commit_group_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [PtrW:0]    r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PtrW'(1);
            if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
            r_count <= r_count + (PtrW+1)'(i_push) - (PtrW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/wb_commit.sv
// Multi-lane writeback/commit: buffers MEM groups, retires one group per cycle
// to the regfile write ports and RVFI with a running order counter.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int unsigned LANES   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ORDER_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_commit_if.slave  io_bus
);

    typedef struct packed {
        logic   [LANES-1:0] live;
        contw_t [LANES-1:0] pkt;
    } group_t;

    localparam int unsigned GroupW = $bits(group_t);

    group_t               w_in_group;
    group_t               w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ready;
    logic [LANES-1:0]     w_commit;
    logic [LANES-1:0]     w_we_raw;
    logic [LANES-1:0]     w_we;
    logic [ORDER_W-1:0]   w_order_d;
    logic [ORDER_W-1:0]   r_order_q;

    always_comb begin
        w_in_group.pkt = io_bus.wb_pkt;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_in_group.live[i] = io_bus.wb_valid[i] && !io_bus.wb_pkt[i].imem_stall;
        end
    end

    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == ($clog2(DEPTH)+1)'(DEPTH));
    assign w_pop   = !w_empty && !io_bus.commit_stall && !io_bus.flush;
    assign w_ready = !w_full || w_pop;
    // Groups with no live lane are acknowledged but never buffered.
    assign w_push  = (|io_bus.wb_valid) && w_ready && !io_bus.flush && (|w_in_group.live);

    wb_commit_group_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (GroupW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (io_bus.flush),
        .i_data  (w_in_group),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_commit = '0;
        w_we_raw = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_commit[i] = w_pop && w_head.live[i] && is_retiring(w_head.pkt[i].state);
            w_we_raw[i] = w_commit[i] && is_reg_writer(w_head.pkt[i].state)
                          && (w_head.pkt[i].rd_s != 5'd0);
        end
        // Within a group the highest lane wins a shared destination.
        w_we = w_we_raw;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (w_we_raw[i] && w_we_raw[j] && (w_head.pkt[i].rd_s == w_head.pkt[j].rd_s)) begin
                    w_we[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [ORDER_W-1:0] run;
        run = r_order_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            io_bus.rvfi_order[i] = w_pop ? run : '0;
            io_bus.rd_s_wb[i]    = w_pop ? w_head.pkt[i].rd_s : 5'd0;
            io_bus.rd_v_wb[i]    = w_pop ? w_head.pkt[i].rd_v : 32'd0;
            io_bus.contw_rvfi[i] = w_commit[i] ? w_head.pkt[i] : '0;
            if (w_commit[i]) run = run + ORDER_W'(1);
        end
        w_order_d = run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_order_q <= '0;
        else        r_order_q <= w_order_d;
    end

    assign io_bus.wb_ready = w_ready;
    assign io_bus.commit   = w_commit;
    assign io_bus.regf_we  = w_we;

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
Parametrised multi-lane writeback/commit stage; successor to the single-lane combinational WB.
- Accepts groups of up to LANES completed instructions from MEM through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Retires one group per cycle: drives the regfile write ports and forwarding, and emits RVFI commits with a running 64-bit order counter.
- Sits between MEM and regfile/RVFI, and decouples WB from RVFI/regfile back-pressure.

Parameters:
LANES, 2, instructions per group (regfile write ports)
DEPTH, 4, FIFO entries (groups); power of two, >=2
ORDER_W, 64, width of RVFI order counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
wb_valid  in  LANES  per-lane valid of incoming group
wb_pkt  in  LANES x contw_t  per-lane control/data word (state, rd_s, rd_v, imem_stall, ...)
wb_ready  out  1  group accepted when any wb_valid bit set and wb_ready=1
flush  in  1  discard all buffered groups
commit_stall  in  1  hold FIFO head; no retirement this cycle
regf_we  out  LANES  per-lane regfile write enable
rd_s_wb  out  LANES x 5  destination register
rd_v_wb  out  LANES x 32  write data
commit  out  LANES  per-lane RVFI commit strobe
rvfi_order  out  LANES x ORDER_W  order number of each committing lane
contw_rvfi  out  LANES x contw_t  packet to RVFI (zero when lane not committing)

Behaviour:
- Reset (rst=0, async): FIFO empty, order_q=0. wb_ready=1; all other outputs 0.
- Lane is live iff wb_valid[i] && !wb_pkt[i].imem_stall. A group with no live lanes is not pushed, but wb_ready is still reported.
- Push: wb_ready = (count<DEPTH) || pop. Push when any wb_valid && wb_ready && !flush. Pushing when full is legal only with a simultaneous pop.
- Pop: pop = !empty && !commit_stall && !flush.
- Retirement latency: a group pushed in cycle t appears at the head in t+1; it retires that cycle if not stalled. No empty-FIFO bypass.
- Head outputs (combinational from head registers, gated by pop):
  - commit[i] = live[i] && state in {s_lui, s_aupic, s_jal, s_jalr, s_br, s_load, s_store, s_ri, s_rr}.
  - regf_we[i] = commit[i] && state not in {s_br, s_store} && rd_s!=0.
- Intra-group WAW: if lanes i<j both have regf_we and equal rd_s, lane i's regf_we is cleared. Lane i still commits.
- Order:
  - rvfi_order[i] = order_q + (number of commit bits in lanes < i).
  - order_q += popcount(commit) on pop.
  - Wraps modulo 2^ORDER_W.
- Flush: same cycle, no pop and no push; next cycle count=0. order_q is unchanged. Flush overrides commit_stall.
- commit_stall with full FIFO: wb_ready=0. Head and all outputs held stable until stall drops; pointers wrap modulo DEPTH.
- Reset mid-operation: all buffered groups are lost; no commit for one cycle after release.

Decomposition:
- rv32i_types gains wb_group_t (LANES x contw_t plus valid vector) and a function is_reg_writer(state).
- One natural sub-module: wb_group_fifo (parametrised DEPTH, group width, count, push/pop/flush).
- Lane gating, WAW suppression and order prefix sums stay in the top level.

Test Plan:
- Reset, then push group {s_ri rd=5 v=0x11, s_rr rd=6 v=0x22}. Next cycle: regf_we=11, commit=11, rvfi_order={0,1}; then order_q=2.
- Push group {s_store, s_br}. At head: commit=11, regf_we=00. Group {s_load rd=0} -> commit=1, regf_we=0.
- WAW: lanes both s_ri with rd=7, values 0xA/0xB. Response: regf_we=10 (lane1 only), rd_v_wb[1]=0xB, commit=11.
- Hold commit_stall=1 and push 4 groups: wb_ready=0 after the 4th. Stall=0 with a simultaneous push: wb_ready=1, count stays 4, groups retire in order.
- 3 groups buffered, assert flush for one cycle: no commit that cycle, wb_ready=1 next. The next group commits with order continuing from the last retired value.
- Preload order_q near 2^ORDER_W-1 (force). A 2-lane commit gives orders {max, 0}; order_q=1.
